ball_engine: RTL and testbench
==============================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: visible lines.
REQ-003 SHALL have parameter BALL_SIZE, default 10: square ball edge in pixels.
REQ-004 SHALL have parameter SPEED_W, default 3: width of the speed magnitude.
REQ-005 SHALL have parameter PAD_L_X / PAD_R_X / PAD_H, defaults 30 / 600 / 64: paddle face x-positions and paddle height.
REQ-006 SHALL have parameter SERVE_FRAMES, default 60: frames between a goal and the next launch.
REQ-007 SHALL have port clk25M, input, 1: pixel clock.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port x, y, input, 10 each: current raster coordinate.
REQ-010 SHALL have port vga_on, input, 1: active-video qualifier.
REQ-011 SHALL have port pad_l_y, pad_r_y, input, 10 each: paddle top edges.
REQ-012 SHALL have port start, input, 1: level; launches play from IDLE.
REQ-013 SHALL have port ball_x, ball_y, output, 10 each: ball top-left corner.
REQ-014 SHALL have port ball_on, output, 1: raster pixel lies inside ball and vga_on=1.
REQ-015 SHALL have port rgb, output, 3: 3'b010 when ball_on, else 3'b000.
REQ-016 SHALL have port goal_l, goal_r, output, 1 each: one-cycle pulse, left/right player scored.

Function
REQ-017 SHALL generate frame_tick for one cycle when x==0 and y==V_ACTIVE+1; position and velocity update only on frame_tick.
REQ-018 SHALL implement states IDLE, SERVE, PLAY, GOAL; IDLE->SERVE on start=1 at frame_tick; SERVE->PLAY after SERVE_FRAMES ticks; PLAY->GOAL on miss; GOAL->SERVE on next tick.
REQ-019 SHALL hold the ball centred, (H_ACTIVE-BALL_SIZE)/2 and (V_ACTIVE-BALL_SIZE)/2, in IDLE and SERVE.
REQ-020 SHALL in PLAY move each axis by the current speed (1..2^SPEED_W-1) in its direction bit; y grows downward.
REQ-021 SHALL on a next top <=0 clamp y to 0 and set direction down; on next bottom >=V_ACTIVE-1 clamp y to V_ACTIVE-BALL_SIZE and set direction up; all arithmetic in 11 bits signed to avoid wrap.
REQ-022 SHALL bounce off the left paddle when moving left, next left <=PAD_L_X, and vertical ball span overlaps [pad_l_y, pad_l_y+PAD_H-1]: clamp x to PAD_L_X+1, set direction right; mirrored for the right paddle at PAD_R_X.
REQ-023 SHALL, when left <=0 without paddle overlap, pulse goal_r and enter GOAL; mirrored at right edge >=H_ACTIVE-1 pulsing goal_l.
REQ-024 SHALL evaluate paddle hit before goal in the same frame; a simultaneous wall and paddle hit (corner) flips both directions in that frame.
REQ-025 SHALL serve toward the player who conceded the last goal; the first serve after reset goes right, down, speed 1.
REQ-026 SHALL ignore start outside IDLE; deassertion of start does not stop play.
REQ-027 SHALL compute ball_on and rgb combinationally from the registered ball_x, ball_y with zero-cycle latency.

Reset
REQ-028 SHALL on reset=0 force state IDLE, the centred position, speed 1, direction right/down, goal_l=goal_r=0, and clear the serve counter, including mid-frame or mid-play.

Configuration
REQ-029 SHALL, with BALL_SPEEDUP_EN defined, increment speed by 1 on each paddle hit, saturating at 2^SPEED_W-1, and reset speed to 1 on a goal.
REQ-030 SHALL, without BALL_SPEEDUP_EN, keep speed fixed at 1.

Structure
REQ-031 SHALL place the state enum and the screen constants (H_ACTIVE, V_ACTIVE defaults, rgb colour codes) in shared package pong_pkg.
REQ-032 SHALL contain one sub-module, ball_render, holding the ball_on/rgb pixel compare.

Verification
REQ-033 SHALL cover this case: reset low mid-PLAY -> next cycle ball_x=315, ball_y=235, state IDLE, goals 0.
REQ-034 SHALL cover this case: start=1, SERVE_FRAMES=2 -> ball leaves centre on the 3rd frame_tick, moving +1 in x and +1 in y.
REQ-035 SHALL cover this case: ball_y=2 moving up at speed 3 -> ball_y=0 and direction down at next tick.
REQ-036 SHALL cover this case: ball moving left, x=31, pad_l_y overlapping -> x=31 and direction right; with BALL_SPEEDUP_EN, speed becomes 2.
REQ-037 SHALL cover this case: ball moving left, no paddle overlap, reaching x=0 -> single-cycle goal_r, ball recentred, next serve goes left.
REQ-038 SHALL cover this case: raster at (ball_x+9, ball_y+9) with vga_on=1 -> ball_on=1, rgb=3'b010; at (ball_x+10, ball_y) -> ball_on=0.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong state encoding, screen geometry and colour codes
package pong_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GOAL  = 2'd3
    } ball_state_e;

    localparam int SCREEN_H_ACTIVE = 640;
    localparam int SCREEN_V_ACTIVE = 480;

    localparam logic [2:0] RGB_BALL  = 3'b010;
    localparam logic [2:0] RGB_BLACK = 3'b000;
endpackage

// File: rtl/ball_render.sv
// rtl/ball_render.sv - combinational raster hit test and colour for the square ball
module ball_render
    import pong_pkg::*;
#(
    parameter int BALL_SIZE = 10
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       vga_on_i,
    input  logic [9:0] ball_x_i,
    input  logic [9:0] ball_y_i,
    output logic       ball_on_o,
    output logic [2:0] rgb_o
);
    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, ball_x_i} + 11'(BALL_SIZE);
    assign y_end = {1'b0, ball_y_i} + 11'(BALL_SIZE);

    assign ball_on_o = vga_on_i
                    && (x_i >= ball_x_i) && ({1'b0, x_i} < x_end)
                    && (y_i >= ball_y_i) && ({1'b0, y_i} < y_end);
    assign rgb_o = ball_on_o ? RGB_BALL : RGB_BLACK;
endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - pong ball motion, wall/paddle bounce, goals and serve sequencing
// Define BALL_SPEEDUP_EN to raise the ball speed on every paddle hit.
module ball_engine
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = SCREEN_H_ACTIVE,
    parameter int V_ACTIVE     = SCREEN_V_ACTIVE,
    parameter int BALL_SIZE    = 10,
    parameter int SPEED_W      = 3,
    parameter int PAD_L_X      = 30,
    parameter int PAD_R_X      = 600,
    parameter int PAD_H        = 64,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk25M,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       vga_on,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    input  logic       start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_on,
    output logic [2:0] rgb,
    output logic       goal_l,
    output logic       goal_r
);
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [9:0]         CX      = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]         CY      = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [10:0] BS      = 11'(BALL_SIZE);
    localparam logic signed [10:0] PH      = 11'(PAD_H);
    localparam logic signed [10:0] PL_X    = 11'(PAD_L_X);
    localparam logic signed [10:0] PR_X    = 11'(PAD_R_X);
    localparam logic signed [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic signed [10:0] V_LAST  = 11'(V_ACTIVE - 1);
    localparam logic signed [10:0] Y_BOT   = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [SPEED_W-1:0] SPD_ONE = SPEED_W'(1);
`ifdef BALL_SPEEDUP_EN
    localparam logic [SPEED_W-1:0] SPD_MAX = {SPEED_W{1'b1}};
`endif

    ball_state_e        state_q;
    logic [9:0]         ball_x_q, ball_y_q;
    logic               dir_x_q, dir_y_q;   // 1 = right / down
    logic [SPEED_W-1:0] speed_q;
    logic [CNT_W-1:0]   serve_cnt_q;
    logic               goal_l_q, goal_r_q;

    logic               frame_tick, step;
    logic signed [10:0] spd_s, nx, ny, y_new, pl_s, pr_s;
    logic               dir_y_new, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

    assign frame_tick = (x == 10'd0) && ({1'b0, y} == 11'(V_ACTIVE + 1));
    // The last serve tick both enters PLAY and launches the ball.
    assign step = frame_tick && ((state_q == ST_PLAY) ||
                                 ((state_q == ST_SERVE) && (serve_cnt_q == SERVE_LAST)));

    always_comb begin
        spd_s     = 11'(speed_q);
        pl_s      = $signed({1'b0, pad_l_y});
        pr_s      = $signed({1'b0, pad_r_y});
        nx        = dir_x_q ? $signed({1'b0, ball_x_q}) + spd_s : $signed({1'b0, ball_x_q}) - spd_s;
        ny        = dir_y_q ? $signed({1'b0, ball_y_q}) + spd_s : $signed({1'b0, ball_y_q}) - spd_s;
        y_new     = ny;
        dir_y_new = dir_y_q;
        if (ny <= 11'sd0) begin
            y_new     = 11'sd0;
            dir_y_new = 1'b1;
        end else if (ny + BS - 11'sd1 >= V_LAST) begin
            y_new     = Y_BOT;
            dir_y_new = 1'b0;
        end
        ovl_l  = (y_new - PH + 11'sd1 <= pl_s) && (y_new + BS - 11'sd1 >= pl_s);
        ovl_r  = (y_new - PH + 11'sd1 <= pr_s) && (y_new + BS - 11'sd1 >= pr_s);
        hit_l  = !dir_x_q && (nx <= PL_X) && ovl_l;
        hit_r  = dir_x_q && (nx + BS - 11'sd1 >= PR_X) && ovl_r;
        miss_l = !dir_x_q && (nx <= 11'sd0);
        miss_r = dir_x_q && (nx + BS - 11'sd1 >= H_LAST);
    end

    always_ff @(posedge clk25M or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ball_x_q    <= CX;
            ball_y_q    <= CY;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            speed_q     <= SPD_ONE;
            serve_cnt_q <= '0;
            goal_l_q    <= 1'b0;
            goal_r_q    <= 1'b0;
        end else begin
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
            if (frame_tick) begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        state_q     <= ST_SERVE;
                        serve_cnt_q <= '0;
                    end
                    ST_SERVE: if (serve_cnt_q == SERVE_LAST) state_q <= ST_PLAY;
                              else serve_cnt_q <= serve_cnt_q + 1'b1;
                    ST_GOAL: begin
                        state_q     <= ST_SERVE;
                        serve_cnt_q <= '0;
                    end
                    default: ;
                endcase
                if (step) begin
                    ball_y_q <= y_new[9:0];
                    dir_y_q  <= dir_y_new;
                    if (hit_l || hit_r) begin
                        ball_x_q <= hit_l ? 10'(PAD_L_X + 1) : 10'(PAD_R_X - BALL_SIZE);
                        dir_x_q  <= hit_l;
`ifdef BALL_SPEEDUP_EN
                        if (speed_q != SPD_MAX) speed_q <= speed_q + 1'b1;
`endif
                    end else if (miss_l || miss_r) begin
                        // Next serve heads toward the player who conceded.
                        goal_r_q <= miss_l;
                        goal_l_q <= miss_r;
                        dir_x_q  <= miss_r;
                        state_q  <= ST_GOAL;
                        ball_x_q <= CX;
                        ball_y_q <= CY;
                        speed_q  <= SPD_ONE;
                    end else begin
                        ball_x_q <= nx[9:0];
                    end
                end
            end
        end
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;
    assign goal_l = goal_l_q;
    assign goal_r = goal_r_q;

    ball_render #(.BALL_SIZE(BALL_SIZE)) u_render (
        .x_i      (x),
        .y_i      (y),
        .vga_on_i (vga_on),
        .ball_x_i (ball_x_q),
        .ball_y_i (ball_y_q),
        .ball_on_o(ball_on),
        .rgb_o    (rgb)
    );
endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - scoreboard bench for ball_engine: serve, bounces, paddle hit, goal, reset, render
module tb_ball_engine;
    logic       clk25M = 1'b0;
    logic       reset;
    logic [9:0] x, y, pad_l_y, pad_r_y;
    logic       vga_on, start;
    logic [9:0] ball_x, ball_y;
    logic       ball_on, goal_l, goal_r;
    logic [2:0] rgb;

    always #5 clk25M = ~clk25M;

    ball_engine #(.SERVE_FRAMES(2)) dut (
        .clk25M (clk25M),
        .reset  (reset),
        .x      (x),
        .y      (y),
        .vga_on (vga_on),
        .pad_l_y(pad_l_y),
        .pad_r_y(pad_r_y),
        .start  (start),
        .ball_x (ball_x),
        .ball_y (ball_y),
        .ball_on(ball_on),
        .rgb    (rgb),
        .goal_l (goal_l),
        .goal_r (goal_r)
    );

    typedef struct { int tick; int ex; int ey; } pos_exp_t;
    typedef struct { int tick; logic l; logic r; } goal_exp_t;

    pos_exp_t  pos_q[$];
    goal_exp_t goal_q[$];
    int tests  = 0;
    int failed = 0;
    int issued = 0;
    int seen   = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void expect_pos(input int t, input int ex, input int ey);
        pos_q.push_back('{t, ex, ey});
    endfunction

    task automatic do_tick();
        @(negedge clk25M);
        x = 10'd0;
        y = 10'd481;
        @(negedge clk25M);
        x = 10'd700;
        y = 10'd700;
        issued++;
    endtask

    task automatic run_to(input int t);
        while (issued < t) do_tick();
    endtask

    // Position monitor: compares on the cycle after each frame tick.
    initial begin
        pos_exp_t e;
        forever begin
            @(posedge clk25M);
            if (reset === 1'b1 && x == 10'd0 && y == 10'd481) begin
                seen++;
                #1;
                while (pos_q.size() > 0 && pos_q[0].tick <= seen) begin
                    e = pos_q.pop_front();
                    tests++;
                    if (e.tick != seen || ball_x !== 10'(e.ex) || ball_y !== 10'(e.ey)) begin
                        failed++;
                        $display("FAIL pos_tick%0d: ball=(%0d,%0d) at tick %0d expected (%0d,%0d)",
                                 e.tick, ball_x, ball_y, seen, e.ex, e.ey);
                    end
                end
            end
        end
    end

    // Goal monitor: every asserted pulse cycle must match one expectation.
    initial begin
        goal_exp_t g;
        forever begin
            @(negedge clk25M);
            if (goal_l !== 1'b0 || goal_r !== 1'b0) begin
                tests++;
                if (goal_q.size() == 0) begin
                    failed++;
                    $display("FAIL goal_unexpected: goal_l=%0b goal_r=%0b at tick %0d expected none",
                             goal_l, goal_r, seen);
                end else begin
                    g = goal_q.pop_front();
                    if (goal_l !== g.l || goal_r !== g.r || seen != g.tick) begin
                        failed++;
                        $display("FAIL goal_tick%0d: goal_l=%0b goal_r=%0b at tick %0d expected l=%0b r=%0b",
                                 g.tick, goal_l, goal_r, seen, g.l, g.r);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1);
    end

    initial begin
        int g1, g2, i0;
        x = 10'd700; y = 10'd700; vga_on = 1'b0; start = 1'b0;
        pad_l_y = 10'd100; pad_r_y = 10'd400; reset = 1'b0;
        repeat (3) @(negedge clk25M);
        check("rst_ball_x", ball_x, 315);
        check("rst_ball_y", ball_y, 235);
        check("rst_goal_l", goal_l, 0);
        check("rst_goal_r", goal_r, 0);
        reset = 1'b1;

        @(negedge clk25M);
        vga_on = 1'b1; x = 10'd324; y = 10'd244; #1;
        check("render_far_corner_on", ball_on, 1);
        check("render_far_corner_rgb", rgb, 2);
        x = 10'd325; y = 10'd235; #1;
        check("render_right_edge_off", ball_on, 0);
        check("render_off_rgb", rgb, 0);
        x = 10'd315; y = 10'd235; #1;
        check("render_origin_on", ball_on, 1);
        x = 10'd314; #1;
        check("render_left_off", ball_on, 0);
        x = 10'd320; y = 10'd245; #1;
        check("render_bottom_off", ball_on, 0);
        vga_on = 1'b0; y = 10'd240; #1;
        check("render_blanked_off", ball_on, 0);
        x = 10'd700; y = 10'd700;

        // Idle ticks without start keep the ball centred.
        expect_pos(1, 315, 235);
        expect_pos(2, 315, 235);
        run_to(2);

        // Game 1: serve, bottom wall, right paddle, top wall, left paddle.
        g1 = issued;
        expect_pos(g1 + 1, 315, 235);
        expect_pos(g1 + 2, 315, 235);
        expect_pos(g1 + 3, 316, 236);
        expect_pos(g1 + 236, 549, 469);
        expect_pos(g1 + 237, 550, 470);
        expect_pos(g1 + 238, 551, 469);
        expect_pos(g1 + 277, 590, 430);
        expect_pos(g1 + 278, 590, 429);
        expect_pos(g1 + 279, 589, 428);
        expect_pos(g1 + 450, 418, 257);
        expect_pos(g1 + 706, 162, 1);
        expect_pos(g1 + 707, 161, 0);
        expect_pos(g1 + 708, 160, 1);
        expect_pos(g1 + 837, 31, 130);
        expect_pos(g1 + 838, 31, 131);
        expect_pos(g1 + 839, 32, 132);
        start = 1'b1;
        run_to(g1 + 3);
        start = 1'b0;
        run_to(g1 + 400);
        start = 1'b1;
        run_to(g1 + 402);
        start = 1'b0;
        run_to(g1 + 839);

        // Reset in the middle of play.
        @(negedge clk25M);
        reset = 1'b0;
        @(negedge clk25M);
        check("midplay_rst_x", ball_x, 315);
        check("midplay_rst_y", ball_y, 235);
        check("midplay_rst_goals", {30'd0, goal_l, goal_r}, 0);
        reset = 1'b1;
        i0 = issued;
        expect_pos(i0 + 1, 315, 235);
        expect_pos(i0 + 2, 315, 235);
        run_to(i0 + 2);

        // Game 2: left paddle moved away, ball reaches x=0.
        g2 = issued;
        pad_l_y = 10'd400;
        expect_pos(g2 + 1, 315, 235);
        expect_pos(g2 + 3, 316, 236);
        expect_pos(g2 + 278, 590, 429);
        expect_pos(g2 + 707, 161, 0);
        expect_pos(g2 + 837, 31, 130);
        expect_pos(g2 + 838, 30, 131);
        expect_pos(g2 + 867, 1, 160);
        expect_pos(g2 + 868, 315, 235);
        goal_q.push_back('{g2 + 868, 1'b0, 1'b1});
        expect_pos(g2 + 869, 315, 235);
        expect_pos(g2 + 870, 315, 235);
        expect_pos(g2 + 871, 314, 236);
        expect_pos(g2 + 872, 313, 237);
        start = 1'b1;
        run_to(g2 + 3);
        start = 1'b0;
        run_to(g2 + 872);
        repeat (4) @(negedge clk25M);

        check("pos_expectations_left", pos_q.size(), 0);
        check("goal_expectations_left", goal_q.size(), 0);
        check("ticks_seen", seen, issued);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
